pipe_stage_elastic: RTL and testbench

PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

---
 rtl/pipe_stage_elastic.sv | 99 +++++++++
 tb/tb_pipe_stage_elastic.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic decode->execute pipeline register: one main entry plus an optional
// skid entry so in_ready can be registered and cut the out_ready timing path.
module pipe_stage_elastic #(
    parameter int                CTRL_W   = 16,
    parameter int                DATA_W   = 133,
    parameter int                SKID     = 1,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    logic              main_vld_q, main_vld_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_vld_q, skid_vld_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              accept, drain;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = ~skid_vld_q;
        end else begin : g_noskid
            assign in_ready = out_ready | ~main_vld_q;
        end
    endgenerate

    assign accept = in_valid & in_ready & ~flush;
    assign drain  = main_vld_q & out_ready;

    // Skid entry can only be written when main is full and stalled; with SKID=0
    // in_ready is low in exactly that case, so the skid entry stays empty.
    always_comb begin
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_vld_d  = 1'b0;
            main_ctrl_d = CTRL_NOP;
            skid_vld_d  = 1'b0;
        end else if (!main_vld_q || drain) begin
            if (skid_vld_q) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_vld_d  = 1'b0;
            end else if (accept) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else begin
                main_vld_d  = 1'b0;
                main_ctrl_d = CTRL_NOP;
            end
        end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= CTRL_NOP;
            main_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_ctrl_q <= CTRL_NOP;
            skid_data_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign out_valid = main_vld_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and scoreboarded checks of pipe_stage_elastic; dut a is SKID=1, dut b is SKID=0.
module tb_pipe_stage_elastic;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [15:0]  a_in_ctrl, a_out_ctrl;
    logic [132:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [15:0]  b_in_ctrl, b_out_ctrl;
    logic [132:0] b_in_data, b_out_data;
    logic [1:0]   b_occ;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.SKID(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .flush(a_flush), .occupancy(a_occ));

    pipe_stage_elastic #(.SKID(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .flush(b_flush), .occupancy(b_occ));

    function automatic logic [132:0] mk_data(input logic [15:0] c);
        return {5'h1b, {4{c}}, ~{4{c}}};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        a_in_valid = 0; a_out_ready = 0; a_flush = 0; a_in_ctrl = 0; a_in_data = 0;
        b_in_valid = 0; b_out_ready = 0; b_flush = 0; b_in_ctrl = 0; b_in_data = 0;
    endtask

    task automatic put_a(input logic [15:0] c);
        a_in_valid = 1; a_in_ctrl = c; a_in_data = mk_data(c);
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_a got %0b want 0", a_out_valid); end
        n_cmp++; if (a_out_ctrl !== 16'h0) begin n_err++; $display("FAIL reset_ctrl_a got %h want 0000", a_out_ctrl); end
        n_cmp++; if (a_out_data !== 133'h0) begin n_err++; $display("FAIL reset_data_a got %h want 0", a_out_data); end
        n_cmp++; if (a_occ !== 2'd0) begin n_err++; $display("FAIL reset_occ_a got %0d want 0", a_occ); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_a got %0b want 1", a_in_ready); end
        n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_b got %0b want 1", b_in_ready); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_b got %0b want 0", b_out_valid); end
        cyc(); cyc();
        rst = 0;
    endtask

    task automatic test_single();
        cyc(); put_a(16'h0005); a_in_data = 133'hA; a_out_ready = 1; #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %0b want 1", a_in_ready); end
        cyc(); a_in_valid = 0; #1;
        n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b want 1", a_out_valid); end
        n_cmp++; if (a_out_ctrl !== 16'h0005) begin n_err++; $display("FAIL single_ctrl got %h want 0005", a_out_ctrl); end
        n_cmp++; if (a_out_data !== 133'hA) begin n_err++; $display("FAIL single_data got %h want a", a_out_data); end
        cyc(); #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL single_after_valid got %0b want 0", a_out_valid); end
        n_cmp++; if (a_out_ctrl !== 16'h0000) begin n_err++; $display("FAIL single_after_ctrl got %h want 0000", a_out_ctrl); end
        idle();
    endtask

    task automatic test_skid_fill();
        cyc(); put_a(16'h0011); a_out_ready = 0; #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL skid_A_ready got %0b want 1", a_in_ready); end
        cyc(); put_a(16'h0012); #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL skid_B_ready got %0b want 1", a_in_ready); end
        n_cmp++; if (a_occ !== 2'd1) begin n_err++; $display("FAIL skid_B_occ got %0d want 1", a_occ); end
        cyc(); put_a(16'h0013); #1;
        n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL skid_full_ready got %0b want 0", a_in_ready); end
        n_cmp++; if (a_occ !== 2'd2) begin n_err++; $display("FAIL skid_full_occ got %0d want 2", a_occ); end
        n_cmp++; if (a_out_ctrl !== 16'h0011) begin n_err++; $display("FAIL skid_full_ctrl got %h want 0011", a_out_ctrl); end
        cyc(); #1;
        n_cmp++; if (a_out_data !== mk_data(16'h0011)) begin n_err++; $display("FAIL skid_stall_data got %h want %h", a_out_data, mk_data(16'h0011)); end
        n_cmp++; if (a_occ !== 2'd2) begin n_err++; $display("FAIL skid_stall_occ got %0d want 2", a_occ); end
        cyc(); a_out_ready = 1; #1;
        n_cmp++; if (a_out_ctrl !== 16'h0011 || a_out_valid !== 1'b1) begin n_err++; $display("FAIL skid_outA got %h/%0b want 0011/1", a_out_ctrl, a_out_valid); end
        n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL skid_drain_ready got %0b want 0", a_in_ready); end
        cyc(); #1;
        n_cmp++; if (a_out_ctrl !== 16'h0012 || a_out_valid !== 1'b1) begin n_err++; $display("FAIL skid_outB got %h/%0b want 0012/1", a_out_ctrl, a_out_valid); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL skid_reopen_ready got %0b want 1", a_in_ready); end
        cyc(); a_in_valid = 0; #1;
        n_cmp++; if (a_out_ctrl !== 16'h0013 || a_out_valid !== 1'b1) begin n_err++; $display("FAIL skid_outC got %h/%0b want 0013/1", a_out_ctrl, a_out_valid); end
        n_cmp++; if (a_occ !== 2'd1) begin n_err++; $display("FAIL skid_outC_occ got %0d want 1", a_occ); end
        cyc(); #1;
        n_cmp++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin n_err++; $display("FAIL skid_empty got %0b/%0d want 0/0", a_out_valid, a_occ); end
        idle();
    endtask

    task automatic test_flush();
        cyc(); put_a(16'h0021); a_out_ready = 0;
        cyc(); put_a(16'h0022);
        cyc(); put_a(16'h0023); a_flush = 1; #1;
        n_cmp++; if (a_occ !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ got %0d want 2", a_occ); end
        cyc(); a_flush = 0; a_in_valid = 0; a_out_ready = 1; #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b want 0", a_out_valid); end
        n_cmp++; if (a_out_ctrl !== 16'h0000) begin n_err++; $display("FAIL flush_ctrl got %h want 0000", a_out_ctrl); end
        n_cmp++; if (a_occ !== 2'd0) begin n_err++; $display("FAIL flush_occ got %0d want 0", a_occ); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %0b want 1", a_in_ready); end
        cyc(); #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_leak got %0b want 0", a_out_valid); end
        idle();
    endtask

    task automatic test_async_reset();
        cyc(); put_a(16'h0031); a_out_ready = 0;
        cyc(); a_in_valid = 0; #1;
        n_cmp++; if (a_occ !== 2'd1) begin n_err++; $display("FAIL arst_pre_occ got %0d want 1", a_occ); end
        #1 rst = 1; #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %0b want 0", a_out_valid); end
        n_cmp++; if (a_occ !== 2'd0) begin n_err++; $display("FAIL arst_occ got %0d want 0", a_occ); end
        n_cmp++; if (a_out_ctrl !== 16'h0 || a_out_data !== 133'h0) begin n_err++; $display("FAIL arst_bundle got %h/%h want 0/0", a_out_ctrl, a_out_data); end
        #1 rst = 0;
        cyc(); a_out_ready = 1; #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL arst_release1 got %0b want 0", a_out_valid); end
        cyc(); #1;
        n_cmp++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin n_err++; $display("FAIL arst_release2 got %0b/%0d want 0/0", a_out_valid, a_occ); end
        idle();
    endtask

    task automatic test_skid0();
        cyc(); b_in_valid = 1; b_in_ctrl = 16'h0051; b_in_data = mk_data(16'h0051); b_out_ready = 0; #1;
        n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL s0_ready_empty got %0b want 1", b_in_ready); end
        cyc(); b_in_ctrl = 16'h0052; b_in_data = mk_data(16'h0052); #1;
        n_cmp++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL s0_ready_full got %0b want 0", b_in_ready); end
        n_cmp++; if (b_occ !== 2'd1) begin n_err++; $display("FAIL s0_occ got %0d want 1", b_occ); end
        cyc(); b_out_ready = 1; #1;
        n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL s0_ready_pass got %0b want 1", b_in_ready); end
        n_cmp++; if (b_out_ctrl !== 16'h0051) begin n_err++; $display("FAIL s0_out1 got %h want 0051", b_out_ctrl); end
        cyc(); b_in_valid = 0; #1;
        n_cmp++; if (b_out_ctrl !== 16'h0052 || b_out_data !== mk_data(16'h0052)) begin n_err++; $display("FAIL s0_out2 got %h want 0052", b_out_ctrl); end
        cyc(); #1;
        n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL s0_empty got %0b want 0", b_out_valid); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] c;
        for (int i = 0; i < 12; i++) begin
            cyc();
            c = 16'h0040 + 16'(i);
            a_out_ready = 1; b_out_ready = 1;
            a_in_valid = (i < 10); b_in_valid = (i < 10);
            a_in_ctrl = c; a_in_data = mk_data(c); b_in_ctrl = c; b_in_data = mk_data(c);
            #1;
            if (i >= 1 && i <= 10) begin
                n_cmp++; if (a_out_valid !== 1'b1 || a_out_ctrl !== c - 16'd1) begin n_err++; $display("FAIL b2b_a[%0d] got %0b/%h want 1/%h", i, a_out_valid, a_out_ctrl, c - 16'd1); end
                n_cmp++; if (b_out_valid !== 1'b1 || b_out_ctrl !== c - 16'd1) begin n_err++; $display("FAIL b2b_b[%0d] got %0b/%h want 1/%h", i, b_out_valid, b_out_ctrl, c - 16'd1); end
            end
            if (i < 10) begin
                n_cmp++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %0b/%0b want 1/1", i, a_in_ready, b_in_ready); end
            end
        end
        idle();
    endtask

    task automatic test_random();
        logic [15:0] qa[$], qb[$];
        logic [15:0] e;
        int sa = 0, sb = 0, ra = 0, rb = 0, cycles = 0;
        while ((ra < 100 || rb < 100) && cycles < 4000) begin
            cyc(); cycles++;
            a_in_valid = (sa < 100) && ($urandom_range(0, 3) != 0);
            a_in_ctrl = 16'h0100 + 16'(sa); a_in_data = mk_data(a_in_ctrl);
            a_out_ready = $urandom_range(0, 1) != 0;
            b_in_valid = (sb < 100) && ($urandom_range(0, 3) != 0);
            b_in_ctrl = 16'h0200 + 16'(sb); b_in_data = mk_data(b_in_ctrl);
            b_out_ready = $urandom_range(0, 1) != 0;
            #1;
            if (a_out_valid && a_out_ready) begin
                e = (qa.size() > 0) ? qa.pop_front() : 16'hxxxx;
                ra++;
                n_cmp++; if (a_out_ctrl !== e || a_out_data !== mk_data(e)) begin n_err++; $display("FAIL rand_a_order got %h want %h", a_out_ctrl, e); end
            end
            if (b_out_valid && b_out_ready) begin
                e = (qb.size() > 0) ? qb.pop_front() : 16'hxxxx;
                rb++;
                n_cmp++; if (b_out_ctrl !== e || b_out_data !== mk_data(e)) begin n_err++; $display("FAIL rand_b_order got %h want %h", b_out_ctrl, e); end
            end
            if (a_in_valid && a_in_ready) begin qa.push_back(a_in_ctrl); sa++; end
            if (b_in_valid && b_in_ready) begin qb.push_back(b_in_ctrl); sb++; end
            n_cmp++; if (a_occ > 2'd2 || b_occ > 2'd1) begin n_err++; $display("FAIL rand_occ got %0d/%0d want <=2/<=1", a_occ, b_occ); end
            n_cmp++; if (!a_out_valid && a_out_ctrl !== 16'h0) begin n_err++; $display("FAIL rand_nop got %h want 0000", a_out_ctrl); end
        end
        n_cmp++; if (ra != 100 || rb != 100) begin n_err++; $display("FAIL rand_count got %0d/%0d want 100/100", ra, rb); end
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_skid_fill();
        test_flush();
        test_async_reset();
        test_skid0();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
